alu_packet_ctrl: RTL and testbench
==================================

ALU_PACKET_CTRL -- requirements
Module: alu_packet_ctrl

Interface
REQ-001 SHALL have parameter LenW, default 16, packet length field width in bits (fixed at 16 for this protocol).
REQ-002 SHALL have port clk_i  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports rx_data_i input 8, rx_valid_i input 1, rx_ready_o output 1  UART RX byte stream.
REQ-005 SHALL have ports tx_data_o output 8, tx_valid_o output 1, tx_ready_i input 1  UART TX byte stream.
REQ-006 SHALL have ports mdu_op_o output 1 (0=mul, 1=div), mdu_a_o output 32, mdu_b_o output 32, mdu_valid_o output 1, mdu_ready_i input 1  request to shared multi-cycle mul/div unit.
REQ-007 SHALL have ports mdu_result_i input 32, mdu_done_i input 1  result and single-cycle completion pulse.
REQ-008 SHALL have port busy_o  output 1  high whenever state is not IDLE.

Function
REQ-009 SHALL parse packets: byte0 opcode, byte1 reserved (ignored), byte2 len low, byte3 len high; len counts all bytes including header.
REQ-010 SHALL support opcodes 0xEC echo, 0xAD add32, 0x4D mul32, 0xD1 div32; others are unknown.
REQ-011 SHALL implement states IDLE, HDR, ECHO, OPND, EXEC, SEND, DRAIN.
REQ-012 IDLE->HDR on first accepted byte; HDR->ECHO/OPND/DRAIN after byte3 per opcode; any state with zero remaining payload jumps to SEND (arith), IDLE (echo/unknown).
REQ-013 Len < 4 SHALL be treated as len = 4 (no payload).
REQ-014 All handshakes: transfer when valid && ready; valid and data SHALL hold stable until transfer.
REQ-015 ECHO: rx_ready_o = !tx_valid_o || tx_ready_i; each accepted byte appears on tx_data_o with tx_valid_o the next cycle.
REQ-016 OPND: collect 4 bytes little-endian into operand; rx_ready_o high only in HDR, OPND, DRAIN, ECHO.
REQ-017 Accumulator SHALL clear to 0 at each header; first operand of mul/div loads accumulator directly.
REQ-018 Add: acc <= acc + operand (mod 2^32) on the cycle operand byte 3 is accepted; no EXEC.
REQ-019 Mul/div (non-first operand): enter EXEC, drive mdu_a_o=acc, mdu_b_o=operand, mdu_valid_o until mdu_ready_i, then wait mdu_done_i; acc <= mdu_result_i; return to OPND or SEND.
REQ-020 Payload bytes beyond the last whole 4-byte operand SHALL be accepted and discarded.
REQ-021 SEND: emit acc as 4 bytes LSB first, then IDLE.
REQ-022 Unknown opcode: DRAIN consumes len-4 bytes, emits nothing.
REQ-023 Controller SHALL not interpret divide-by-zero; result is whatever the unit returns.
REQ-024 mdu_done_i outside EXEC SHALL be ignored.

Reset
REQ-025 On rst_ni low: state IDLE, counters and acc 0, all valid/ready outputs 0, tx_data_o 0, mdu_* outputs 0, busy_o 0.
REQ-026 Reset mid-packet SHALL abandon the packet; first byte after release is parsed as a new header.

Configuration
REQ-027 With ALU_CTRL_DIV_EN defined, opcode 0xD1 SHALL be div32; without it 0xD1 SHALL be unknown (DRAIN) and mdu_op_o tied 0.

Structure
REQ-028 Shared package alu_ctrl_pkg SHALL hold state enum, opcode constants, mdu op encoding.
REQ-029 Sub-module alu_ctrl_hdr (header byte counter/length capture) SHALL be the one natural split; rest is flat.

Verification
REQ-030 Echo: EC 00 07 00 41 42 43 -> TX 41 42 43, then idle.
REQ-031 Add: AD 00 0C 00 FF FF FF FF 02 00 00 00 -> TX 01 00 00 00 (wrap).
REQ-032 Mul with 3-cycle model unit: 4D 00 0C 00 03 00 00 00 05 00 00 00 -> one mdu request a=3 b=5, TX 0F 00 00 00.
REQ-033 Unknown 77 00 06 00 AA BB then EC 00 05 00 11 -> TX only 11.
REQ-034 tx_ready_i held low 10 cycles during SEND -> tx_valid_o and tx_data_o stable, no byte lost.
REQ-035 rst_ni pulsed after 2 operand bytes of an add packet -> no TX; following echo packet handled correctly.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the packet-driven ALU controller.
// Divide support depends on the ALU_CTRL_DIV_EN macro in the top level.
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ECHO,
        ST_OPND,
        ST_EXEC,
        ST_SEND,
        ST_DRAIN
    } state_e;

    typedef enum logic [2:0] {
        OP_ECHO,
        OP_ADD,
        OP_MUL,
        OP_DIV,
        OP_UNK
    } op_kind_e;

    localparam logic [7:0] OPC_ECHO = 8'hEC;
    localparam logic [7:0] OPC_ADD  = 8'hAD;
    localparam logic [7:0] OPC_MUL  = 8'h4D;
    localparam logic [7:0] OPC_DIV  = 8'hD1;

    localparam logic MDU_OP_MUL = 1'b0;
    localparam logic MDU_OP_DIV = 1'b1;

    function automatic op_kind_e decode_op(input logic [7:0] opc, input logic div_en);
        op_kind_e kind;
        case (opc)
            OPC_ECHO: kind = OP_ECHO;
            OPC_ADD:  kind = OP_ADD;
            OPC_MUL:  kind = OP_MUL;
            OPC_DIV:  kind = div_en ? OP_DIV : OP_UNK;
            default:  kind = OP_UNK;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_ctrl_hdr.sv
// Header byte counter: captures the opcode and length of a packet and
// reports the payload length (len minus the 4 header bytes, floored at 0).
module alu_ctrl_hdr #(
    parameter int LenW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            fire_i,
    input  logic [7:0]      data_i,
    output logic [7:0]      opcode_o,
    output logic            last_o,
    output logic [LenW-1:0] pay_len_o
);

    logic [1:0]      cnt_q;
    logic [7:0]      len_lo_q;
    logic [LenW-1:0] len_full;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= 2'd0;
            opcode_o <= 8'h00;
            len_lo_q <= 8'h00;
        end else if (fire_i) begin
            cnt_q <= cnt_q + 2'd1;
            if (cnt_q == 2'd0) opcode_o <= data_i;
            if (cnt_q == 2'd2) len_lo_q <= data_i;
        end
    end

    // Valid only while the high length byte is on data_i.
    assign last_o    = (cnt_q == 2'd3);
    assign len_full  = LenW'({data_i, len_lo_q});
    assign pay_len_o = (len_full < LenW'(4)) ? '0 : len_full - LenW'(4);

endmodule

// File: rtl/alu_packet_ctrl.sv
// UART packet controller: echo, add32, mul32 and optional div32 (enabled
// by defining ALU_CTRL_DIV_EN) using a shared multi-cycle mul/div unit.
module alu_packet_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int LenW = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        mdu_op_o,
    output logic [31:0] mdu_a_o,
    output logic [31:0] mdu_b_o,
    output logic        mdu_valid_o,
    input  logic        mdu_ready_i,
    input  logic [31:0] mdu_result_i,
    input  logic        mdu_done_i,
    output logic        busy_o
);

`ifdef ALU_CTRL_DIV_EN
    localparam logic DivEn = 1'b1;
`else
    localparam logic DivEn = 1'b0;
`endif

    state_e          state_q, state_d;
    op_kind_e        op_kind;
    logic [7:0]      opcode;
    logic            hdr_last;
    logic [LenW-1:0] pay_len, rem_q;
    logic [31:0]     acc_q, opnd_q, opnd_word;
    logic [1:0]      opnd_idx_q, send_idx_q;
    logic            first_q, mdu_valid_q, tx_valid_q;
    logic [7:0]      tx_data_q, tx_load_data;
    logic            is_mdu, is_arith, rem_last;
    logic            rx_fire, tx_fire, tx_slot, tx_load;
    logic            hdr_done, opnd_full, exec_done;

    alu_ctrl_hdr #(.LenW(LenW)) u_hdr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .fire_i    (state_q == ST_HDR && rx_fire),
        .data_i    (rx_data_i),
        .opcode_o  (opcode),
        .last_o    (hdr_last),
        .pay_len_o (pay_len)
    );

    assign op_kind   = decode_op(opcode, DivEn);
    assign is_mdu    = (op_kind == OP_MUL) || (op_kind == OP_DIV);
    assign is_arith  = is_mdu || (op_kind == OP_ADD);
    assign rem_last  = (rem_q == LenW'(1));
    assign rx_fire   = rx_valid_i && rx_ready_o;
    assign tx_fire   = tx_valid_q && tx_ready_i;
    assign tx_slot   = !tx_valid_q || tx_ready_i;
    assign hdr_done  = (state_q == ST_HDR) && rx_fire && hdr_last;
    assign opnd_full = (state_q == ST_OPND) && rx_fire && (opnd_idx_q == 2'd3);
    assign opnd_word = {rx_data_i, opnd_q[23:0]};
    // A completion pulse counts only once the request has been handed over.
    assign exec_done = (state_q == ST_EXEC) && !mdu_valid_q && mdu_done_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        rx_ready_o   = 1'b0;
        tx_load      = 1'b0;
        tx_load_data = '0;
        case (state_q)
            ST_IDLE: if (rx_valid_i) state_d = ST_HDR;
            ST_HDR: begin
                rx_ready_o = 1'b1;
                if (hdr_done) begin
                    if (pay_len == '0)             state_d = is_arith ? ST_SEND : ST_IDLE;
                    else if (op_kind == OP_ECHO)   state_d = ST_ECHO;
                    else if (is_arith)             state_d = ST_OPND;
                    else                           state_d = ST_DRAIN;
                end
            end
            ST_ECHO: begin
                rx_ready_o = tx_slot;
                if (rx_fire) begin
                    tx_load      = 1'b1;
                    tx_load_data = rx_data_i;
                    if (rem_last) state_d = ST_IDLE;
                end
            end
            ST_OPND: begin
                rx_ready_o = 1'b1;
                if (opnd_full && is_mdu && !first_q) state_d = ST_EXEC;
                else if (rx_fire && rem_last)         state_d = ST_SEND;
            end
            ST_EXEC: if (exec_done) state_d = (rem_q == '0) ? ST_SEND : ST_OPND;
            ST_SEND: begin
                if (tx_slot) begin
                    tx_load      = 1'b1;
                    tx_load_data = acc_q[{send_idx_q, 3'b000} +: 8];
                    if (send_idx_q == 2'd3) state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                rx_ready_o = 1'b1;
                if (rx_fire && rem_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            opnd_idx_q  <= 2'd0;
            send_idx_q  <= 2'd0;
            first_q     <= 1'b0;
            mdu_valid_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
        end else begin
            if (hdr_done) begin
                rem_q      <= pay_len;
                acc_q      <= '0;
                opnd_idx_q <= 2'd0;
                send_idx_q <= 2'd0;
                first_q    <= 1'b1;
            end else if (rx_fire && (state_q inside {ST_ECHO, ST_OPND, ST_DRAIN})) begin
                rem_q <= rem_q - LenW'(1);
            end

            if (state_q == ST_OPND && rx_fire) begin
                opnd_q[{opnd_idx_q, 3'b000} +: 8] <= rx_data_i;
                opnd_idx_q <= opnd_idx_q + 2'd1;
            end

            // The first mul/div operand seeds the accumulator without a request.
            if (opnd_full) begin
                if (op_kind == OP_ADD) begin
                    acc_q <= acc_q + opnd_word;
                end else if (first_q) begin
                    acc_q   <= opnd_word;
                    first_q <= 1'b0;
                end
            end else if (exec_done) begin
                acc_q <= mdu_result_i;
            end

            if (opnd_full && is_mdu && !first_q) mdu_valid_q <= 1'b1;
            else if (mdu_valid_q && mdu_ready_i) mdu_valid_q <= 1'b0;

            if (tx_load) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= tx_load_data;
            end else if (tx_fire) begin
                tx_valid_q <= 1'b0;
            end
            if (state_q == ST_SEND && tx_load) send_idx_q <= send_idx_q + 2'd1;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign mdu_valid_o = mdu_valid_q;
    assign mdu_a_o     = acc_q;
    assign mdu_b_o     = opnd_q;
`ifdef ALU_CTRL_DIV_EN
    assign mdu_op_o    = (op_kind == OP_DIV) ? MDU_OP_DIV : MDU_OP_MUL;
`else
    assign mdu_op_o    = MDU_OP_MUL;
`endif

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Self-checking bench for alu_packet_ctrl: directed vector table, corner
// sequences, and random packets against a packet-level reference model.
module tb_alu_packet_ctrl;

`ifdef ALU_CTRL_DIV_EN
    localparam bit DivEn = 1'b1;
`else
    localparam bit DivEn = 1'b0;
`endif

    logic        clk_i, rst_ni;
    logic [7:0]  rx_data_i;
    logic        rx_valid_i, rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o, tx_ready_i;
    logic        mdu_op_o;
    logic [31:0] mdu_a_o, mdu_b_o;
    logic        mdu_valid_o, mdu_ready_i;
    logic [31:0] mdu_result_i;
    logic        mdu_done_i;
    logic        busy_o;

    alu_packet_ctrl #(.LenW(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_data_i    (rx_data_i),
        .rx_valid_i   (rx_valid_i),
        .rx_ready_o   (rx_ready_o),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .mdu_op_o     (mdu_op_o),
        .mdu_a_o      (mdu_a_o),
        .mdu_b_o      (mdu_b_o),
        .mdu_valid_o  (mdu_valid_o),
        .mdu_ready_i  (mdu_ready_i),
        .mdu_result_i (mdu_result_i),
        .mdu_done_i   (mdu_done_i),
        .busy_o       (busy_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    typedef struct {
        string        name;
        int           n;
        logic [127:0] pkt;
        int           n_exp;
        logic [63:0]  exp;
        int           n_req;
        logic [31:0]  a;
        logic [31:0]  b;
    } vec_t;

    vec_t        vecs[$];
    int          n_pass, n_total;
    logic [7:0]  pkt_q[$], exp_q[$], tx_q[$];
    int          exp_req, req_cnt, mdu_busy, tx_mode;
    bit          spur, gap_mode;
    logic [31:0] last_a, last_b, mdu_res;
    logic        last_op;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out, got no response, wanted completion", name);
    endtask

    task automatic check_tx(input string name);
        bit    ok;
        string s_act, s_exp;
        ok = (tx_q.size() == exp_q.size());
        s_act = "";
        s_exp = "";
        foreach (tx_q[i]) s_act = {s_act, $sformatf(" %02h", tx_q[i])};
        foreach (exp_q[i]) begin
            s_exp = {s_exp, $sformatf(" %02h", exp_q[i])};
            if (ok && tx_q[i] !== exp_q[i]) ok = 1'b0;
        end
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: tx bytes [%s ] wanted [%s ]", name, s_act, s_exp);
    endtask

    // Packet-level reference: interpret pkt_q as a whole packet.
    function automatic void ref_model();
        int          len, nops;
        logic [31:0] acc, w;
        logic [7:0]  opc;
        exp_q.delete();
        exp_req = 0;
        opc = pkt_q[0];
        len = int'({pkt_q[3], pkt_q[2]});
        if (len < 4) len = 4;
        nops = (len - 4) / 4;
        if (opc == 8'hEC) begin
            for (int i = 4; i < len; i++) exp_q.push_back(pkt_q[i]);
        end else if (opc == 8'hAD || opc == 8'h4D || (opc == 8'hD1 && DivEn)) begin
            acc = 32'd0;
            for (int k = 0; k < nops; k++) begin
                w = {pkt_q[4*k+7], pkt_q[4*k+6], pkt_q[4*k+5], pkt_q[4*k+4]};
                if (opc == 8'hAD) acc = acc + w;
                else if (k == 0) acc = w;
                else begin
                    exp_req++;
                    if (opc == 8'h4D) acc = acc * w;
                    else acc = (w == 0) ? 32'hFFFF_FFFF : acc / w;
                end
            end
            for (int b = 0; b < 4; b++) exp_q.push_back(acc[8*b +: 8]);
        end
    endfunction

    // TX sink: ready policy applied on the falling edge, transfers logged just before the rising edge.
    initial begin
        tx_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            case (tx_mode)
                0:       tx_ready_i = 1'b1;
                1:       tx_ready_i = ($urandom_range(0, 2) != 0);
                default: tx_ready_i = 1'b0;
            endcase
            #4;
            if (rst_ni && tx_valid_o && tx_ready_i) tx_q.push_back(tx_data_o);
        end
    end

    // Mul/div unit model: accepts a request, pulses done 3 cycles later.
    initial begin
        mdu_ready_i  = 1'b0;
        mdu_done_i   = 1'b0;
        mdu_result_i = 32'd0;
        mdu_busy     = 0;
        forever begin
            @(negedge clk_i);
            mdu_done_i = 1'b0;
            if (!rst_ni) mdu_busy = 0;
            if (mdu_busy > 0) begin
                mdu_busy--;
                if (mdu_busy == 0) begin
                    mdu_done_i   = 1'b1;
                    mdu_result_i = mdu_res;
                end
            end else if (spur) begin
                mdu_done_i   = 1'b1;
                mdu_result_i = 32'hDEAD_BEEF;
                spur         = 1'b0;
            end
            mdu_ready_i = (mdu_busy == 0) && !mdu_done_i && ($urandom_range(0, 3) != 0);
            #4;
            if (rst_ni && mdu_valid_o && mdu_ready_i) begin
                mdu_busy = 3;
                last_a   = mdu_a_o;
                last_b   = mdu_b_o;
                last_op  = mdu_op_o;
                if (!mdu_op_o) mdu_res = mdu_a_o * mdu_b_o;
                else mdu_res = (mdu_b_o == 0) ? 32'hFFFF_FFFF : mdu_a_o / mdu_b_o;
                req_cnt++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waitc = 0;
        if (gap_mode) repeat ($urandom_range(0, 2)) @(negedge clk_i);
        @(negedge clk_i);
        rx_valid_i = 1'b1;
        rx_data_i  = b;
        #4;
        while (!rx_ready_o) begin
            waitc++;
            if (waitc > 300) begin
                fail_now("rx byte accept");
                rx_valid_i = 1'b0;
                return;
            end
            @(negedge clk_i);
            #4;
        end
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int c = 0;
        @(negedge clk_i);
        while ((busy_o || tx_valid_o || mdu_busy > 0) && c < 500) begin
            @(negedge clk_i);
            c++;
        end
        if (c >= 500) fail_now({name, " idle"});
        repeat (2) @(negedge clk_i);
    endtask

    task automatic run_pkt(input string name);
        tx_q.delete();
        req_cnt = 0;
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        wait_quiet(name);
        check_tx(name);
        check({name, " mdu requests"}, 64'(req_cnt), 64'(exp_req));
    endtask

    task automatic add_vec(input string nm, input int n, input logic [127:0] p, input int ne,
                           input logic [63:0] e, input int nr, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        v.name = nm; v.n = n; v.pkt = p; v.n_exp = ne; v.exp = e;
        v.n_req = nr; v.a = a; v.b = b;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] held;
        int         c;
        n_pass = 0; n_total = 0;
        tx_mode = 0; spur = 1'b0; gap_mode = 1'b0;
        rx_valid_i = 1'b0; rx_data_i = 8'h00;
        rst_ni = 1'b0;

        add_vec("echo",      7, 128'hEC0007_00414243, 3, 64'h414243, 0, 0, 0);
        add_vec("add wrap", 12, 128'hAD000C00_FFFFFFFF_02000000, 4, 64'h01000000, 0, 0, 0);
        add_vec("mul",      12, 128'h4D000C00_03000000_05000000, 4, 64'h0F000000, 1, 32'd3, 32'd5);
        add_vec("unknown",   6, 128'h77000600_AABB, 0, 64'h0, 0, 0, 0);
        add_vec("echo 11",   5, 128'hEC000500_11, 1, 64'h11, 0, 0, 0);
        add_vec("len<4",     4, 128'hAD000200, 4, 64'h00000000, 0, 0, 0);
        add_vec("echo len0", 4, 128'hEC000000, 0, 64'h0, 0, 0, 0);
        add_vec("add tail", 10, 128'hAD000A00_05000000_AABB, 4, 64'h05000000, 0, 0, 0);
        add_vec("mul one",   8, 128'h4D000800_07000000, 4, 64'h07000000, 0, 0, 0);
        add_vec("mul three",16, 128'h4D001000_02000000_03000000_04000000, 4, 64'h18000000, 2, 32'd6, 32'd4);
        add_vec("mul wrap", 12, 128'h4D000C00_00000100_00000100, 4, 64'h00000000, 1, 32'h10000, 32'h10000);
        if (DivEn) add_vec("div", 12, 128'hD1000C00_0A000000_02000000, 4, 64'h05000000, 1, 32'd10, 32'd2);
        else       add_vec("div off", 12, 128'hD1000C00_0A000000_02000000, 0, 64'h0, 0, 0, 0);

        #2;
        check("reset busy_o", 64'(busy_o), 64'd0);
        check("reset rx_ready_o", 64'(rx_ready_o), 64'd0);
        check("reset tx_valid_o", 64'(tx_valid_o), 64'd0);
        check("reset tx_data_o", 64'(tx_data_o), 64'd0);
        check("reset mdu_valid_o", 64'(mdu_valid_o), 64'd0);
        check("reset mdu_a_o", 64'(mdu_a_o), 64'd0);
        check("reset mdu_b_o", 64'(mdu_b_o), 64'd0);
        check("reset mdu_op_o", 64'(mdu_op_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        foreach (vecs[v]) begin
            pkt_q.delete();
            exp_q.delete();
            for (int i = 0; i < vecs[v].n; i++) pkt_q.push_back(vecs[v].pkt[8*(vecs[v].n-1-i) +: 8]);
            for (int i = 0; i < vecs[v].n_exp; i++) exp_q.push_back(vecs[v].exp[8*(vecs[v].n_exp-1-i) +: 8]);
            exp_req = vecs[v].n_req;
            run_pkt(vecs[v].name);
            if (vecs[v].n_req > 0) begin
                check({vecs[v].name, " last mdu a"}, 64'(last_a), 64'(vecs[v].a));
                check({vecs[v].name, " last mdu b"}, 64'(last_b), 64'(vecs[v].b));
                check({vecs[v].name, " mdu op"}, 64'(last_op), 64'(vecs[v].pkt[8*(vecs[v].n-1) +: 8] == 8'hD1));
            end
        end

        // TX stalled during SEND: the pending byte must stay put.
        tx_mode = 2;
        tx_q.delete();
        pkt_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        c = 0;
        @(negedge clk_i); #4;
        while (!tx_valid_o && c < 50) begin @(negedge clk_i); #4; c++; end
        if (c >= 50) fail_now("stall first byte");
        held = tx_data_o;
        check("stall first byte", 64'(held), 64'h78);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i); #4;
            check("stall tx_valid held", 64'(tx_valid_o), 64'd1);
            check("stall tx_data held", 64'(tx_data_o), 64'(held));
        end
        tx_mode = 0;
        exp_q = '{8'h78, 8'h56, 8'h34, 8'h12};
        wait_quiet("stall");
        check_tx("stall send");

        // Reset in the middle of an add packet abandons it.
        tx_q.delete();
        pkt_q = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
        foreach (pkt_q[i]) send_byte(pkt_q[i]);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("mid reset busy_o", 64'(busy_o), 64'd0);
        check("mid reset rx_ready_o", 64'(rx_ready_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check("mid reset tx count", 64'(tx_q.size()), 64'd0);
        pkt_q = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h11};
        exp_q = '{8'h11};
        exp_req = 0;
        run_pkt("echo after reset");

        // A done pulse outside EXEC must not disturb the accumulator.
        tx_q.delete();
        pkt_q = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
        for (int i = 0; i < 6; i++) send_byte(pkt_q[i]);
        spur = 1'b1;
        repeat (3) @(negedge clk_i);
        send_byte(pkt_q[6]);
        send_byte(pkt_q[7]);
        wait_quiet("stray done");
        exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        check_tx("stray done ignored");

        // Random packets with random TX backpressure and RX gaps.
        tx_mode = 1;
        gap_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            logic [7:0] opc;
            int         len, nbytes;
            case ($urandom_range(0, 4))
                0: opc = 8'hEC;
                1: opc = 8'hAD;
                2: opc = 8'h4D;
                3: opc = 8'hD1;
                default: begin
                    opc = 8'($urandom);
                    if (opc inside {8'hEC, 8'hAD, 8'h4D, 8'hD1}) opc = 8'h5A;
                end
            endcase
            len = $urandom_range(0, 20);
            nbytes = (len < 4) ? 4 : len;
            pkt_q.delete();
            pkt_q.push_back(opc);
            pkt_q.push_back(8'($urandom));
            pkt_q.push_back(8'(len));
            pkt_q.push_back(8'h00);
            for (int i = 4; i < nbytes; i++) pkt_q.push_back(8'($urandom));
            ref_model();
            run_pkt($sformatf("random %0d op %02h len %0d", r, opc, len));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
